// File: rtl/evt_tx_manager.sv
// Reads one complete event from every channel FIFO and streams them, in channel order, onto one
// valid/ready port; counts completed readouts in evt_tx. Define EVT_TX_TRAILER_EN to append a count trailer word.
module evt_tx_manager #(
   parameter int N_CH = 2,
   parameter int DW   = 16,
   parameter int LW   = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 need_check,
   input  logic                 need_read,
   input  logic [N_CH-1:0]      ch_empty,
   input  logic [N_CH*DW-1:0]   ch_dout,
   output logic [N_CH-1:0]      ch_rd_en,
   output logic [DW-1:0]        tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 tx_last,
   output logic [15:0]          evt_tx,
   output logic                 busy
);

   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

`ifdef EVT_TX_TRAILER_EN
   localparam bit HAS_TRL = 1'b1;
`else
   localparam bit HAS_TRL = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_NEXT,
`ifdef EVT_TX_TRAILER_EN
      S_TRL,
`endif
      S_DONE
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_ch;
   logic [LW-1:0]    r_rem;
   logic             r_pending;
   logic [15:0]      r_evt_tx;

   logic [DW-1:0]    w_head;
   logic             w_empty;
   logic [LW-1:0]    w_len;
   logic             w_in_xfer;
   logic             w_valid;
   logic             w_last;
   logic [DW-1:0]    w_data;
   logic             w_hs;

   // Head word and empty flag of the channel currently being read.
   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_head  = '0;
      w_empty = 1'b1;
      for (int k = 0; k < N_CH; k++) begin
         if (r_ch == CW'(k)) begin
            w_head  = ch_dout[k*DW +: DW];
            w_empty = ch_empty[k];
         end
      end
   end

   assign w_len     = w_head[LW-1:0];
   assign w_in_xfer = (r_state == S_HDR) || (r_state == S_DATA);

   // FWFT head is forwarded directly; reset forces the handshake outputs low even mid-readout.
   always_comb begin
      w_valid = 1'b0;
      w_last  = 1'b0;
      w_data  = '0;
      if (!reset) begin
         case (r_state)
            S_HDR: begin
               w_valid = !w_empty;
               w_data  = w_head;
               w_last  = !HAS_TRL && (r_ch == LAST_CH) && (w_len == '0);
            end
            S_DATA: begin
               w_valid = !w_empty;
               w_data  = w_head;
               w_last  = !HAS_TRL && (r_ch == LAST_CH) && (r_rem == LW'(1));
            end
`ifdef EVT_TX_TRAILER_EN
            S_TRL: begin
               w_valid = 1'b1;
               w_data  = DW'(r_evt_tx);
               w_last  = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   assign w_hs     = w_valid && tx_ready;
   assign tx_valid = w_valid;
   assign tx_data  = w_data;
   assign tx_last  = w_last;
   assign ch_rd_en = (w_hs && w_in_xfer) ? (N_CH'(1) << r_ch) : '0;
   assign busy     = !reset && (r_state != S_IDLE);
   assign evt_tx   = r_evt_tx;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ch      <= '0;
         r_rem     <= '0;
         r_pending <= 1'b0;
         r_evt_tx  <= '0;
      end else begin
         if (need_check && (r_state != S_IDLE))
            r_pending <= 1'b1;

         case (r_state)
            S_IDLE: begin
               // A stale request with nothing left to read is dropped here.
               r_ch      <= '0;
               r_pending <= 1'b0;
               if (need_check || (r_pending && need_read))
                  r_state <= S_HDR;
            end
            S_HDR: begin
               if (w_hs) begin
                  if (w_len == '0) begin
                     r_state <= S_NEXT;
                  end else begin
                     r_rem   <= w_len;
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_hs) begin
                  if (r_rem == LW'(1))
                     r_state <= S_NEXT;
                  else
                     r_rem <= r_rem - LW'(1);
               end
            end
            S_NEXT: begin
               if (r_ch == LAST_CH) begin
`ifdef EVT_TX_TRAILER_EN
                  r_state <= S_TRL;
`else
                  r_state <= S_DONE;
`endif
               end else begin
                  r_ch    <= r_ch + CW'(1);
                  r_state <= S_HDR;
               end
            end
`ifdef EVT_TX_TRAILER_EN
            S_TRL: begin
               if (w_hs)
                  r_state <= S_DONE;
            end
`endif
            S_DONE: begin
               r_evt_tx <= r_evt_tx + 16'd1;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
